xintf_slave_port: RTL

XINTF_SLAVE_PORT -- requirements
Module: xintf_slave_port

---
 rtl/xintf_slave_port.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/xintf_slave_port.sv
// rtl/xintf_slave_port.sv - XINTF slave port bridging asynchronous DSP strobes onto TX/RX block-RAM ports
// Optional feature macro: XINTF_TIMEOUT_EN bounds RD_HOLD and WR_WAIT to P_TIMEOUT cycles.
module xintf_slave_port #(
   parameter int P_SYNC_STAGES = 2,
   parameter int P_TX_WORDS    = 43,
   parameter int P_RX_WORDS    = 12,
   parameter int P_TIMEOUT     = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_xintf_cs_n,
   input  logic        i_xintf_rd_n,
   input  logic        i_xintf_we_n,
   input  logic [9:0]  i_xintf_addr,
   input  logic [15:0] i_xintf_data,
   output logic [15:0] o_xintf_data,
   output logic        o_xintf_data_oe,
   output logic [8:0]  o_tx_ram_addr,
   output logic        o_tx_ram_ce,
   input  logic [15:0] i_tx_ram_dout,
   output logic [8:0]  o_rx_ram_addr,
   output logic [15:0] o_rx_ram_din,
   output logic        o_rx_ram_we,
   output logic        o_rx_ram_ce,
   output logic        o_rd_done,
   output logic        o_wr_done,
   output logic [15:0] o_err_cnt
);

   if (P_SYNC_STAGES < 2 || P_TIMEOUT < 1) begin : g_bad_params
      $error("xintf_slave_port: P_SYNC_STAGES must be >= 2 and P_TIMEOUT >= 1");
   end

   localparam logic [9:0] TX_LIM = 10'(P_TX_WORDS);
   localparam logic [9:0] RX_LIM = 10'(P_RX_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      RD_HOLD,
      WR_WAIT,
      WR_COMMIT
   } state_t;

   state_t state;

   logic [P_SYNC_STAGES-1:0] cs_sh;
   logic [P_SYNC_STAGES-1:0] rd_sh;
   logic [P_SYNC_STAGES-1:0] we_sh;
   logic [9:0]               addr_sh [P_SYNC_STAGES];
   logic [15:0]              data_sh [P_SYNC_STAGES];
   logic                     rd_q;
   logic                     we_q;

   logic        cs_s;
   logic        rd_s;
   logic        we_s;
   logic [9:0]  addr_s;
   logic [15:0] data_s;
   logic        rd_fall;
   logic        we_fall;
   logic        we_rise;

   logic [9:0]  lat_addr;
   logic [15:0] lat_data;
   logic        rd_err;
   logic        rd_idx_ok;
   logic        wr_idx_ok;
   logic        tmo_hit;
   logic        err_event;

   // Strobes idle high so that reset never manufactures an edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         cs_sh <= '1;
         rd_sh <= '1;
         we_sh <= '1;
         for (int i = 0; i < P_SYNC_STAGES; i++) begin
            addr_sh[i] <= '0;
            data_sh[i] <= '0;
         end
         rd_q <= 1'b1;
         we_q <= 1'b1;
      end else begin
         cs_sh      <= {cs_sh[P_SYNC_STAGES-2:0], i_xintf_cs_n};
         rd_sh      <= {rd_sh[P_SYNC_STAGES-2:0], i_xintf_rd_n};
         we_sh      <= {we_sh[P_SYNC_STAGES-2:0], i_xintf_we_n};
         addr_sh[0] <= i_xintf_addr;
         data_sh[0] <= i_xintf_data;
         for (int i = 1; i < P_SYNC_STAGES; i++) begin
            addr_sh[i] <= addr_sh[i-1];
            data_sh[i] <= data_sh[i-1];
         end
         rd_q <= rd_s;
         we_q <= we_s;
      end
   end

   assign cs_s    = cs_sh[P_SYNC_STAGES-1];
   assign rd_s    = rd_sh[P_SYNC_STAGES-1];
   assign we_s    = we_sh[P_SYNC_STAGES-1];
   assign addr_s  = addr_sh[P_SYNC_STAGES-1];
   assign data_s  = data_sh[P_SYNC_STAGES-1];
   assign rd_fall = rd_q & ~rd_s;
   assign we_fall = we_q & ~we_s;
   assign we_rise = ~we_q & we_s;

   assign rd_idx_ok = ~addr_s[9] && ({1'b0, addr_s[8:0]} < TX_LIM);
   assign wr_idx_ok = lat_addr[9] && ({1'b0, lat_addr[8:0]} < RX_LIM);

`ifdef XINTF_TIMEOUT_EN
   localparam int TMO_W = $clog2(P_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst || !(state == RD_HOLD || state == WR_WAIT)) begin
         tmo_cnt <= '0;
      end else if (!tmo_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit = (state == RD_HOLD || state == WR_WAIT) && (tmo_cnt == TMO_W'(P_TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // Errors: strobe collision, out-of-range read, out-of-range write at commit, timeout.
   always_comb begin
      err_event = 1'b0;
      case (state)
         IDLE:    err_event = ~cs_s & rd_fall & (we_fall | (we_s & ~rd_idx_ok));
         RD_HOLD: err_event = ~rd_s & ~cs_s & tmo_hit;
         WR_WAIT: err_event = ~cs_s & ((we_rise & ~wr_idx_ok) | (~we_rise & tmo_hit));
         default: err_event = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         o_err_cnt <= '0;
      end else if (err_event && o_err_cnt != 16'hFFFF) begin
         o_err_cnt <= o_err_cnt + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state           <= IDLE;
         o_xintf_data    <= '0;
         o_xintf_data_oe <= 1'b0;
         o_tx_ram_addr   <= '0;
         o_tx_ram_ce     <= 1'b0;
         o_rx_ram_addr   <= '0;
         o_rx_ram_din    <= '0;
         o_rx_ram_we     <= 1'b0;
         o_rx_ram_ce     <= 1'b0;
         o_rd_done       <= 1'b0;
         o_wr_done       <= 1'b0;
         lat_addr        <= '0;
         lat_data        <= '0;
         rd_err          <= 1'b0;
      end else begin
         o_rd_done   <= 1'b0;
         o_wr_done   <= 1'b0;
         o_rx_ram_we <= 1'b0;
         o_rx_ram_ce <= 1'b0;
         case (state)
            IDLE: begin
               if (!cs_s && !(rd_fall && we_fall)) begin
                  if (rd_fall && we_s) begin
                     if (rd_idx_ok) begin
                        state         <= RD_ADDR;
                        o_tx_ram_addr <= addr_s[8:0];
                        o_tx_ram_ce   <= 1'b1;
                        rd_err        <= 1'b0;
                     end else begin
                        state           <= RD_HOLD;
                        o_xintf_data    <= '0;
                        o_xintf_data_oe <= 1'b1;
                        rd_err          <= 1'b1;
                     end
                  end else if (we_fall && rd_s) begin
                     state    <= WR_WAIT;
                     lat_addr <= addr_s;
                     lat_data <= data_s;
                  end
               end
            end
            RD_ADDR: begin
               if (cs_s) begin
                  state       <= IDLE;
                  o_tx_ram_ce <= 1'b0;
               end else begin
                  state <= RD_DATA;
               end
            end
            RD_DATA: begin
               o_tx_ram_ce <= 1'b0;
               if (cs_s) begin
                  state <= IDLE;
               end else begin
                  state           <= RD_HOLD;
                  o_xintf_data    <= i_tx_ram_dout;
                  o_xintf_data_oe <= 1'b1;
               end
            end
            RD_HOLD: begin
               // A strobe release wins over a simultaneous chip-select release.
               if (rd_s) begin
                  state           <= IDLE;
                  o_xintf_data_oe <= 1'b0;
                  o_rd_done       <= ~rd_err;
               end else if (cs_s || tmo_hit) begin
                  state           <= IDLE;
                  o_xintf_data_oe <= 1'b0;
               end
            end
            WR_WAIT: begin
               if (!we_s) begin
                  lat_addr <= addr_s;
                  lat_data <= data_s;
               end
               if (cs_s) begin
                  state <= IDLE;
               end else if (we_rise) begin
                  state <= WR_COMMIT;
                  if (wr_idx_ok) begin
                     o_rx_ram_addr <= lat_addr[8:0];
                     o_rx_ram_din  <= lat_data;
                     o_rx_ram_we   <= 1'b1;
                     o_rx_ram_ce   <= 1'b1;
                     o_wr_done     <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  state <= IDLE;
               end
            end
            WR_COMMIT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
